// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration and lock supervision controller.
// Programs the PLL for NTSC or PAL timing over the reconfig block's
// Avalon-MM management port and holds the core in reset until lock is stable.
module pll_reconfig_ctrl #(
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned LOCK_TIMEOUT   = 1048576,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter logic [31:0] NTSC_M         = 32'h0000_0404,
  parameter logic [31:0] NTSC_K         = 32'hB851_EB85,
  parameter logic [31:0] NTSC_C0        = 32'h0000_0505,
  parameter logic [31:0] PAL_M          = 32'h0000_0505,
  parameter logic [31:0] PAL_K          = 32'h1EB8_51EC,
  parameter logic [31:0] PAL_C0         = 32'h0000_0606
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mode_sel,
  input  logic        pll_locked,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  output logic        pll_rst,
  output logic        core_reset_n,
  output logic        active_mode,
  output logic        busy,
  output logic        done,
  output logic        lock_error
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > PLL_RST_CYCLES) ? SETTLE_CYCLES : PLL_RST_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned SW      = $clog2(LOCK_STABLE + 1);
  localparam int unsigned TW      = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    SETTLE,
    WAIT_LOCK,
    PLL_RESET
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            mode_s1;
  logic            mode_s2;
  logic            lock_s1;
  logic            lock_s2;
  logic            tgt;
  logic [2:0]      idx;
  logic            gap;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   stable_cnt;
  logic [TW-1:0]   tmo_cnt;

  logic beat_done;
  logic last_beat;
  logic settle_hit;
  logic prst_hit;
  logic stable_hit;
  logic tmo_hit;

  assign beat_done  = (state == WRITE) && !gap && !mgmt_waitrequest;
  assign last_beat  = (idx == 3'd4);
  assign settle_hit = (cnt == CW'(SETTLE_CYCLES - 1));
  assign prst_hit   = (cnt == CW'(PLL_RST_CYCLES - 1));
  assign stable_hit = lock_s2 && (stable_cnt == SW'(LOCK_STABLE - 1));
  assign tmo_hit    = (tmo_cnt == TW'(LOCK_TIMEOUT - 1));

  // Two-stage synchronizers for the asynchronous mode request and lock inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_s1 <= 1'b0;
      mode_s2 <= 1'b0;
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      mode_s1 <= mode_sel;
      mode_s2 <= mode_s1;
      lock_s1 <= pll_locked;
      lock_s2 <= lock_s1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT_LOCK;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; lock loss beats a mode change, stable lock beats timeout
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (!lock_s2) begin
          state_next = WAIT_LOCK;
        end else if (mode_s2 != active_mode) begin
          state_next = WRITE;
        end
      end
      WRITE:     if (beat_done && last_beat) state_next = SETTLE;
      SETTLE:    if (settle_hit) state_next = WAIT_LOCK;
      WAIT_LOCK: begin
        if (stable_hit) begin
          state_next = IDLE;
        end else if (tmo_hit) begin
          state_next = PLL_RESET;
        end
      end
      PLL_RESET: if (prst_hit) state_next = WAIT_LOCK;
      default:   state_next = WAIT_LOCK;
    endcase
  end

  // Counters, write sequencing, mode tracking and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgt         <= 1'b0;
      idx         <= '0;
      gap         <= 1'b0;
      cnt         <= '0;
      stable_cnt  <= '0;
      tmo_cnt     <= '0;
      active_mode <= 1'b0;
      done        <= 1'b0;
      lock_error  <= 1'b0;
    end else begin
      // Counters idle at zero outside their state so every entry starts clean
      cnt <= (state == SETTLE || state == PLL_RESET) ? cnt + 1'b1 : '0;
      if (state == WAIT_LOCK) begin
        stable_cnt <= lock_s2 ? stable_cnt + 1'b1 : '0;
        tmo_cnt    <= tmo_cnt + 1'b1;
      end else begin
        stable_cnt <= '0;
        tmo_cnt    <= '0;
      end

      done <= (state == WAIT_LOCK) && stable_hit;

      if (state == WAIT_LOCK) begin
        if (stable_hit) begin
          lock_error <= 1'b0;
        end else if (tmo_hit) begin
          lock_error  <= 1'b1;
          active_mode <= 1'b0;
        end
      end

      if (state == IDLE && lock_s2 && (mode_s2 != active_mode)) begin
        tgt <= mode_s2;
        idx <= '0;
        gap <= 1'b0;
      end

      // One idle cycle separates consecutive write beats
      if (state == WRITE) begin
        if (gap) begin
          gap <= 1'b0;
        end else if (beat_done) begin
          if (last_beat) begin
            active_mode <= tgt;
          end else begin
            idx <= idx + 3'd1;
            gap <= 1'b1;
          end
        end
      end
    end
  end

  // Output decode: management bus from the write table, reset and status lines
  always_comb begin
    mgmt_write     = 1'b0;
    mgmt_address   = '0;
    mgmt_writedata = '0;
    if (state == WRITE) begin
      mgmt_write = !gap;
      case (idx)
        3'd0: begin
          mgmt_address   = 6'd0;
          mgmt_writedata = '0;
        end
        3'd1: begin
          mgmt_address   = 6'd4;
          mgmt_writedata = tgt ? PAL_M : NTSC_M;
        end
        3'd2: begin
          mgmt_address   = 6'd7;
          mgmt_writedata = tgt ? PAL_K : NTSC_K;
        end
        3'd3: begin
          mgmt_address   = 6'd5;
          mgmt_writedata = tgt ? PAL_C0 : NTSC_C0;
        end
        default: begin
          mgmt_address   = 6'd2;
          mgmt_writedata = '0;
        end
      endcase
    end
    pll_rst      = (state == PLL_RESET);
    core_reset_n = (state == IDLE);
    busy         = (state != IDLE);
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed testbench for pll_reconfig_ctrl with short lock/settle parameters.
module tb_pll_reconfig_ctrl;

  localparam logic [31:0] NTSC_M  = 32'h0000_0404;
  localparam logic [31:0] NTSC_K  = 32'hB851_EB85;
  localparam logic [31:0] NTSC_C0 = 32'h0000_0505;
  localparam logic [31:0] PAL_M   = 32'h0000_0505;
  localparam logic [31:0] PAL_K   = 32'h1EB8_51EC;
  localparam logic [31:0] PAL_C0  = 32'h0000_0606;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mode_sel = 1'b0;
  logic        pll_locked = 1'b0;
  logic        mgmt_waitrequest = 1'b0;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        pll_rst;
  logic        core_reset_n;
  logic        active_mode;
  logic        busy;
  logic        done;
  logic        lock_error;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [5:0]  q_addr[$];
  logic [31:0] q_data[$];
  logic        q_mode[$];
  int          q_cyc[$];

  pll_reconfig_ctrl #(
    .LOCK_STABLE    (8),
    .LOCK_TIMEOUT   (64),
    .PLL_RST_CYCLES (4),
    .SETTLE_CYCLES  (4)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .mode_sel         (mode_sel),
    .pll_locked       (pll_locked),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_waitrequest (mgmt_waitrequest),
    .pll_rst          (pll_rst),
    .core_reset_n     (core_reset_n),
    .active_mode      (active_mode),
    .busy             (busy),
    .done             (done),
    .lock_error       (lock_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted write beat, sampled mid-cycle
  always @(negedge clk) begin
    if (reset_n && mgmt_write && !mgmt_waitrequest) begin
      q_addr.push_back(mgmt_address);
      q_data.push_back(mgmt_writedata);
      q_mode.push_back(active_mode);
      q_cyc.push_back(cyc);
    end
  end

  function automatic logic [5:0] exp_addr(input int i);
    case (i)
      0: return 6'd0;
      1: return 6'd4;
      2: return 6'd7;
      3: return 6'd5;
      default: return 6'd2;
    endcase
  endfunction

  function automatic logic [31:0] exp_data(input logic pal, input int i);
    case (i)
      1: return pal ? PAL_M : NTSC_M;
      2: return pal ? PAL_K : NTSC_K;
      3: return pal ? PAL_C0 : NTSC_C0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    q_mode.delete();
    q_cyc.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({mgmt_write, mgmt_address, mgmt_writedata} !== 39'h0) begin
      n_fail++;
      $display("FAIL reset_mgmt: got w=%b a=%0h d=%0h expected all zero", mgmt_write, mgmt_address, mgmt_writedata);
    end
    n_checks++;
    if ({pll_rst, core_reset_n, active_mode} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctl: got pll_rst/core_reset_n/active_mode=%b expected 000", {pll_rst, core_reset_n, active_mode});
    end
    n_checks++;
    if ({busy, done, lock_error} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_status: got busy/done/lock_error=%b expected 100", {busy, done, lock_error});
    end
  endtask

  task automatic test_powerup();
    int  n;
    bit  seen;
    bit  early;
    clear_log();
    reset_n = 1'b1;
    repeat (10) tick();
    pll_locked = 1'b1;
    seen  = 0;
    early = 0;
    for (n = 1; n <= 40; n++) begin
      tick();
      if (done) begin
        seen = 1;
        break;
      end
      if (core_reset_n) early = 1;
    end
    n_checks++;
    if (!seen || n != 10) begin
      n_fail++;
      $display("FAIL powerup_done_latency: got %0d cycles (seen=%0d) expected 10", n, seen);
    end
    n_checks++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL powerup_core_reset_early: got early release=%0d expected 0", early);
    end
    n_checks++;
    if ({core_reset_n, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL powerup_idle: got core_reset_n/busy=%b expected 10", {core_reset_n, busy});
    end
    tick();
    n_checks++;
    if ({done, core_reset_n} !== 2'b01) begin
      n_fail++;
      $display("FAIL powerup_done_pulse: got done/core_reset_n=%b expected 01", {done, core_reset_n});
    end
    n_checks++;
    if (q_addr.size() != 0) begin
      n_fail++;
      $display("FAIL powerup_no_writes: got %0d writes expected 0", q_addr.size());
    end
  endtask

  task automatic test_reconfig_pal();
    int n;
    bit seen;
    clear_log();
    mode_sel = 1'b1;
    seen = 0;
    for (n = 1; n <= 100; n++) begin
      tick();
      if (done) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL pal_done_timeout: got no done in %0d cycles expected done", n);
    end
    n_checks++;
    if (q_addr.size() != 5) begin
      n_fail++;
      $display("FAIL pal_write_count: got %0d expected 5", q_addr.size());
    end
    if (q_addr.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (q_addr[i] !== exp_addr(i) || q_data[i] !== exp_data(1'b1, i) || q_mode[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL pal_beat%0d: got a=%0h d=%0h m=%b expected a=%0h d=%0h m=0",
                   i, q_addr[i], q_data[i], q_mode[i], exp_addr(i), exp_data(1'b1, i));
        end
        if (i > 0) begin
          n_checks++;
          if (q_cyc[i] - q_cyc[i-1] != 2) begin
            n_fail++;
            $display("FAIL pal_beat_spacing%0d: got %0d cycles expected 2", i, q_cyc[i] - q_cyc[i-1]);
          end
        end
      end
    end
    n_checks++;
    if ({active_mode, core_reset_n, lock_error} !== 3'b110) begin
      n_fail++;
      $display("FAIL pal_final: got active_mode/core_reset_n/lock_error=%b expected 110",
               {active_mode, core_reset_n, lock_error});
    end
  endtask

  task automatic test_waitrequest();
    int n;
    int hold;
    bit seen;
    clear_log();
    mode_sel = 1'b0;
    seen = 0;
    for (n = 1; n <= 100; n++) begin
      tick();
      if (mgmt_write && mgmt_address == 6'd7) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_k_beat_seen: got no addr 7 write in %0d cycles expected one", n);
    end
    mgmt_waitrequest = 1'b1;
    hold = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mgmt_waitrequest = 1'b0;
      if (mgmt_write === 1'b1 && mgmt_address === 6'd7 && mgmt_writedata === NTSC_K) hold++;
      tick();
    end
    n_checks++;
    if (hold != 4) begin
      n_fail++;
      $display("FAIL wait_hold_stable: got %0d stable cycles expected 4", hold);
    end
    n_checks++;
    if (mgmt_write !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_gap: got mgmt_write=%b expected 0", mgmt_write);
    end
    seen = 0;
    for (n = 1; n <= 100; n++) begin
      tick();
      if (done) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (!seen || q_addr.size() != 5) begin
      n_fail++;
      $display("FAIL wait_write_count: got %0d writes (done=%0d) expected 5", q_addr.size(), seen);
    end
    if (q_addr.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (q_addr[i] !== exp_addr(i) || q_data[i] !== exp_data(1'b0, i)) begin
          n_fail++;
          $display("FAIL wait_beat%0d: got a=%0h d=%0h expected a=%0h d=%0h",
                   i, q_addr[i], q_data[i], exp_addr(i), exp_data(1'b0, i));
        end
      end
    end
    n_checks++;
    if (active_mode !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_active_mode: got %b expected 0", active_mode);
    end
  endtask

  task automatic test_settle_toggle();
    int n;
    bit seen;
    clear_log();
    mode_sel = 1'b1;
    seen = 0;
    for (n = 1; n <= 100; n++) begin
      tick();
      if (mgmt_write && mgmt_address == 6'd2) begin
        seen = 1;
        break;
      end
    end
    tick();
    n_checks++;
    if (!seen || {busy, mgmt_write} !== 2'b10) begin
      n_fail++;
      $display("FAIL toggle_in_settle: got seen=%0d busy/write=%b expected seen=1 10", seen, {busy, mgmt_write});
    end
    mode_sel = 1'b0;
    tick();
    mode_sel = 1'b1;
    tick();
    mode_sel = 1'b0;
    seen = 0;
    for (n = 1; n <= 100; n++) begin
      tick();
      if (done) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (!seen || active_mode !== 1'b1) begin
      n_fail++;
      $display("FAIL toggle_first_done: got done=%0d active_mode=%b expected 1 1", seen, active_mode);
    end
    seen = 0;
    for (n = 1; n <= 150; n++) begin
      tick();
      if (done) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (!seen || active_mode !== 1'b0) begin
      n_fail++;
      $display("FAIL toggle_second_done: got done=%0d active_mode=%b expected 1 0", seen, active_mode);
    end
    n_checks++;
    if (q_addr.size() != 10) begin
      n_fail++;
      $display("FAIL toggle_write_count: got %0d expected 10", q_addr.size());
    end
    if (q_addr.size() >= 10) begin
      for (int i = 0; i < 10; i++) begin
        n_checks++;
        if (q_addr[i] !== exp_addr(i % 5) || q_data[i] !== exp_data(i < 5, i % 5)) begin
          n_fail++;
          $display("FAIL toggle_beat%0d: got a=%0h d=%0h expected a=%0h d=%0h",
                   i, q_addr[i], q_data[i], exp_addr(i % 5), exp_data(i < 5, i % 5));
        end
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    int width;
    bit seen;
    clear_log();
    mode_sel = 1'b1;
    seen = 0;
    for (n = 1; n <= 100; n++) begin
      tick();
      if (mgmt_write && mgmt_address == 6'd2) begin
        seen = 1;
        break;
      end
    end
    pll_locked = 1'b0;
    for (n = 1; n <= 150; n++) begin
      tick();
      if (lock_error) break;
    end
    n_checks++;
    if (!seen || n != 69) begin
      n_fail++;
      $display("FAIL tmo_latency: got %0d cycles (start seen=%0d) expected 69", n, seen);
    end
    n_checks++;
    if ({pll_rst, active_mode, core_reset_n, lock_error} !== 4'b1001) begin
      n_fail++;
      $display("FAIL tmo_entry: got pll_rst/active_mode/core_reset_n/lock_error=%b expected 1001",
               {pll_rst, active_mode, core_reset_n, lock_error});
    end
    width = 1;
    for (n = 1; n <= 20; n++) begin
      tick();
      if (pll_rst) width++;
      else break;
    end
    n_checks++;
    if (width != 4) begin
      n_fail++;
      $display("FAIL tmo_pll_rst_width: got %0d expected 4", width);
    end
    n_checks++;
    if ({lock_error, active_mode} !== 2'b10) begin
      n_fail++;
      $display("FAIL tmo_after_rst: got lock_error/active_mode=%b expected 10", {lock_error, active_mode});
    end
    pll_locked = 1'b1;
    seen = 0;
    for (n = 1; n <= 60; n++) begin
      tick();
      if (done) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (!seen || {lock_error, active_mode} !== 2'b00) begin
      n_fail++;
      $display("FAIL tmo_relock: got done=%0d lock_error/active_mode=%b expected 1 00", seen, {lock_error, active_mode});
    end
    seen = 0;
    for (n = 1; n <= 150; n++) begin
      tick();
      if (done) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (!seen || {active_mode, lock_error} !== 2'b10 || q_addr.size() != 10) begin
      n_fail++;
      $display("FAIL tmo_rerun: got done=%0d active_mode/lock_error=%b writes=%0d expected 1 10 10",
               seen, {active_mode, lock_error}, q_addr.size());
    end
    if (q_addr.size() >= 10) begin
      for (int i = 5; i < 10; i++) begin
        n_checks++;
        if (q_addr[i] !== exp_addr(i - 5) || q_data[i] !== exp_data(1'b1, i - 5)) begin
          n_fail++;
          $display("FAIL tmo_rerun_beat%0d: got a=%0h d=%0h expected a=%0h d=%0h",
                   i - 5, q_addr[i], q_data[i], exp_addr(i - 5), exp_data(1'b1, i - 5));
        end
      end
    end
  endtask

  task automatic test_lock_drop();
    int         n;
    bit         seen;
    bit         early;
    logic [2:0] rst_trace;
    clear_log();
    tick();
    pll_locked = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      rst_trace[2 - k] = core_reset_n;
    end
    pll_locked = 1'b1;
    n_checks++;
    if (rst_trace !== 3'b110) begin
      n_fail++;
      $display("FAIL drop_core_reset_trace: got %b expected 110", rst_trace);
    end
    seen  = 0;
    early = 0;
    for (n = 4; n <= 40; n++) begin
      tick();
      if (done) begin
        seen = 1;
        break;
      end
      if (core_reset_n) early = 1;
    end
    n_checks++;
    if (!seen || n != 13 || early) begin
      n_fail++;
      $display("FAIL drop_relock: got done at %0d (seen=%0d early=%0d) expected 13", n, seen, early);
    end
    n_checks++;
    if (q_addr.size() != 0 || active_mode !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_no_writes: got writes=%0d active_mode=%b expected 0 1", q_addr.size(), active_mode);
    end
  endtask

  task automatic test_reset_mid_beat();
    int n;
    bit seen;
    clear_log();
    mode_sel = 1'b0;
    seen = 0;
    for (n = 1; n <= 60; n++) begin
      tick();
      if (mgmt_write && mgmt_address == 6'd4) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (!seen || mgmt_writedata !== NTSC_M) begin
      n_fail++;
      $display("FAIL abort_idx1_seen: got seen=%0d d=%0h expected 1 %0h", seen, mgmt_writedata, NTSC_M);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({mgmt_write, mgmt_address, mgmt_writedata} !== 39'h0) begin
      n_fail++;
      $display("FAIL abort_mgmt: got w=%b a=%0h d=%0h expected all zero", mgmt_write, mgmt_address, mgmt_writedata);
    end
    n_checks++;
    if ({active_mode, busy, core_reset_n} !== 3'b010) begin
      n_fail++;
      $display("FAIL abort_ctl: got active_mode/busy/core_reset_n=%b expected 010", {active_mode, busy, core_reset_n});
    end
    repeat (2) tick();
    reset_n = 1'b1;
    seen = 0;
    for (n = 1; n <= 40; n++) begin
      tick();
      if (done) begin
        seen = 1;
        break;
      end
    end
    repeat (5) tick();
    n_checks++;
    if (!seen || q_addr.size() != 1 || {active_mode, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_recover: got done=%0d writes=%0d active_mode/busy=%b expected 1 1 00",
               seen, q_addr.size(), {active_mode, busy});
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_reconfig_pal();
    test_waitrequest();
    test_settle_toggle();
    test_timeout();
    test_lock_drop();
    test_reset_mid_beat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
